delay_pipe_arbiter: RTL and testbench
=====================================

# delay_pipe_arbiter

Round-robin scheduler that shares one fixed-latency 1-bit delay line (a `DELAY`-stage shift register) among `N_REQ` requesters. Grants at most one issue per cycle, drives the delay line input, and tracks the owner of every in-flight token in an internal tag pipeline. Routes each delayed completion back to its issuer as a `done` pulse. Enforces a per-requester outstanding-token limit. Sits between client engines and a shift-register delay line instance in the core.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `DELAY`, 8, latency of the external delay line in cycles (>= 2); must equal that instance's `DELAY`
- `MAX_OUT`, 3, max in-flight tokens per requester (>= 1)

- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous reset, active low
- `en`  in  1  arbitration enable; low blocks new grants, in-flight tokens still complete
- `req`  in  N_REQ  level request per requester
- `gnt`  out  N_REQ  registered one-hot issue pulse
- `done`  out  N_REQ  registered one-hot completion pulse
- `pipe_din`  out  1  to delay line `din`
- `pipe_dout`  in  1  from delay line `dout`
- `busy`  out  1  any requester has tokens in flight
- `err`  out  1  sticky delay-line mismatch flag (see Configuration)

## Operation
- Eligibility: requester i is eligible when `req[i]` && `cnt[i] < MAX_OUT` && `en`.
- Arbiter: round-robin pointer `ptr` (width clog2(N_REQ)); search starts at `ptr`, wraps past N_REQ-1 to 0; first eligible index wins. After granting index i, `ptr` <= (i+1) mod N_REQ; with no grant, `ptr` holds.
- Issue: winner registered into `gnt`; `pipe_din` = OR of `gnt` (same register stage). At most one grant per cycle.
- Tag pipeline: DELAY-stage pipe of {valid, tag}; stage 0 loads {|gnt, index of gnt}; stage DELAY-1 output aligns with `pipe_dout`.
- Completion: when the tag pipe output is valid, `done[tag]` pulses the next cycle.
- Counters `cnt[i]` (width clog2(MAX_OUT+1)): +1 on `gnt[i]`, -1 on `done[i]`; both in the same cycle leaves `cnt[i]` unchanged. No overflow is possible because eligibility gates on `MAX_OUT`.
- `busy` = OR over all `cnt[i] != 0`, registered.
- `en` deasserting mid-stream stops grants from the next arbitration. Pipe contents and counters are untouched.

## Timing
- Reset values: `gnt`=0, `done`=0, `pipe_din`=0, `busy`=0, `err`=0, `ptr`=0, all `cnt`=0, all tag-pipe valids=0.
- Latency: `req` sampled at edge t gives `gnt` and `pipe_din` high in cycle t+1. The matching `pipe_dout` is high in cycle t+1+DELAY. `done` is high in cycle t+2+DELAY.
- Back-to-back: a single requester with `MAX_OUT` >= DELAY+2 can be granted every cycle. Otherwise it stalls after `MAX_OUT` grants until its first `done`.
- A grant and a done to the same requester in one cycle: the counter holds, and the requester stays eligible if it was below `MAX_OUT`.
- Reset mid-operation: all in-flight tags are discarded and no `done` is produced for them. The external delay line has no reset, so stale `pipe_dout` pulses can emerge for DELAY cycles after `reset_n` rises. The mismatch check is masked during that window by a post-reset counter.

## Configuration
- `DELAY_PIPE_ARBITER_CHECK_EN` defined:
  - Each cycle after the mask window, `pipe_dout` is compared with the tag-pipe output valid.
  - On any mismatch, `err` sets one cycle later and stays set until reset.
  - `done` is always derived from the tag pipe, never from `pipe_dout`.
- Not defined:
  - `err` is tied 0, and `pipe_dout` is ignored.
  - The mask counter and comparator are not built.

## Test plan
- Reset, then single `req[2]` for 1 cycle with `en`=1 and DELAY=8: `gnt[2]` high exactly one cycle at t+1, `done[2]` at t+10, `busy` high in between.
- `req`=4'b1111 held for 8 cycles: grant order 0,1,2,3,0,1,2,3; `done` pulses arrive in the same order DELAY+1 cycles after each grant.
- `req[1]` held with MAX_OUT=3: three grants on consecutive cycles, then `gnt[1]` stays low until `done[1]`, then one grant per `done`.
- `en` dropped after 2 grants with `req`=4'b1111: no further `gnt`; both `done` pulses still arrive; `busy` falls after the last one.
- With the check enabled, force `pipe_dout`=1 for one cycle with no token in flight, after the mask window: `err` rises next cycle and stays high until `reset_n`=0.
- Assert `reset_n`=0 with 3 tokens in flight and release it: no `done` pulses; `err` stays 0 despite stale `pipe_dout` pulses within DELAY cycles.

Source files
------------

// File: rtl/delay_pipe_arbiter.sv
// Round-robin issue of 1-bit tokens onto a shared external delay line, with per-requester
// in-flight limits and completion routing. DELAY_PIPE_ARBITER_CHECK_EN adds a dout/tag check.
module delay_pipe_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DELAY   = 8,
  parameter int MAX_OUT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             pipe_din,
  input  logic             pipe_dout,
  output logic             busy,
  output logic             err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             pipe_din_q, pipe_din_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [DELAY-1:0] vld_q, vld_d;
  logic [IDX_W-1:0] tag_q [DELAY];
  logic [IDX_W-1:0] tag_d [DELAY];
  logic [N_REQ-1:0] elig_s;
  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;
  int               cand_s;

  // Eligibility: requesting, below the in-flight limit, and arbitration enabled.
  // cnt_q already includes the grant currently on gnt, so the limit is never overshot.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = req[i] && (cnt_q[i] < CNT_MAX) && en;
    end
  end

  // Round-robin search starting at ptr, wrapping past the last requester.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = int'(ptr_q) + k;
      if (cand_s >= N_REQ) begin
        cand_s = cand_s - N_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && elig_s[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(cand_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Issue stage: one-hot grant, delay-line input and pointer advance.
  always_comb begin
    gnt_d      = '0;
    gnt_idx_d  = win_idx_s;
    pipe_din_d = win_found_s;
    ptr_d      = ptr_q;
    if (win_found_s) begin
      gnt_d[win_idx_s] = 1'b1;
      ptr_d = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Tag pipeline mirrors the external delay line; its last stage lines up with pipe_dout.
  always_comb begin
    vld_d    = {vld_q[DELAY-2:0], |gnt_q};
    tag_d[0] = gnt_idx_q;
    for (int s = 1; s < DELAY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Completion routing from the tag pipe output.
  always_comb begin
    done_d = '0;
    if (vld_q[DELAY-1]) begin
      done_d[tag_q[DELAY-1]] = 1'b1;
    end else begin
      done_d = '0;
    end
  end

  // In-flight counters move together with the gnt/done registers; busy lags them by one.
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(gnt_d[i]) - CNT_W'(done_d[i]);
      busy_d   = busy_d | (cnt_q[i] != '0);
    end
  end

  // Main state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      done_q     <= '0;
      pipe_din_q <= 1'b0;
      busy_q     <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      for (int s = 0; s < DELAY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      done_q     <= done_d;
      pipe_din_q <= pipe_din_d;
      busy_q     <= busy_d;
      vld_q      <= vld_d;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      for (int s = 0; s < DELAY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign pipe_din = pipe_din_q;
  assign busy     = busy_q;

`ifdef DELAY_PIPE_ARBITER_CHECK_EN
  localparam int MASK_W = $clog2(DELAY + 1);
  localparam logic [MASK_W-1:0] MASK_END = MASK_W'(DELAY);

  logic [MASK_W-1:0] mask_q, mask_d;
  logic              err_q, err_d;

  // The delay line is not reset, so its first DELAY outputs after reset are not trusted.
  always_comb begin
    mask_d = (mask_q == MASK_END) ? mask_q : mask_q + MASK_W'(1);
    err_d  = err_q | ((mask_q == MASK_END) & (pipe_dout != vld_q[DELAY-1]));
  end

  // Mask counter and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_pipe_dout_s;
  assign unused_pipe_dout_s = pipe_dout;
  assign err                = 1'b0;
`endif

endmodule

// File: tb/tb_delay_pipe_arbiter.sv
// Scoreboard bench for delay_pipe_arbiter: directed stimulus queues expected gnt/done events,
// a negedge monitor pops and compares them; a local shift register models the delay line.
module tb_delay_pipe_arbiter;

  localparam int N_REQ   = 4;
  localparam int DELAY   = 8;
  localparam int MAX_OUT = 3;
`ifdef DELAY_PIPE_ARBITER_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             pipe_din;
  logic             pipe_dout;
  logic             busy;
  logic             err;
  logic             force_dout = 1'b0;
  logic [DELAY-1:0] dl_q = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct { int idx; int cyc; } exp_t;
  exp_t gq[$];
  exp_t dq[$];

  delay_pipe_arbiter #(.N_REQ(N_REQ), .DELAY(DELAY), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .pipe_din  (pipe_din),
    .pipe_dout (pipe_dout),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // External delay line model: no reset, DELAY cycles from din to dout.
  always @(posedge clk) dl_q <= {dl_q[DELAY-2:0], pipe_din};
  assign pipe_dout = force_dout | dl_q[DELAY-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_g(input int idx, input int c);
    exp_t e;
    e.idx = idx;
    e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic push_d(input int idx, input int c);
    exp_t e;
    e.idx = idx;
    e.cyc = c;
    dq.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    en      = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every gnt/done pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (gnt != '0) begin
        if (gq.size() == 0) begin
          check("gnt_unexpected", int'(gnt), 0);
        end else begin
          e = gq.pop_front();
          check("gnt_vector", int'(gnt), int'(onehot(e.idx)));
          check("gnt_cycle", cyc, e.cyc);
          check("pipe_din", int'(pipe_din), 1);
        end
      end
      if (done != '0) begin
        if (dq.size() == 0) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          e = dq.pop_front();
          check("done_vector", int'(done), int'(onehot(e.idx)));
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int b;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_pipe_din", int'(pipe_din), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    reset_n = 1'b1;
    en      = 1'b1;
    @(negedge clk);

    // Single request from requester 2
    b = cyc;
    req = 4'b0100;
    push_g(2, b + 1);
    push_d(2, b + 10);
    @(negedge clk);
    req = '0;
    wait_to(b + 5);
    check("t1_busy_mid", int'(busy), 1);
    wait_to(b + 12);
    check("t1_busy_end", int'(busy), 0);

    // All requesting for 8 cycles: strict rotation
    do_reset();
    @(negedge clk);
    b = cyc;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      push_g(k % 4, b + 1 + k);
      push_d(k % 4, b + 10 + k);
    end
    repeat (8) @(negedge clk);
    req = '0;
    wait_to(b + 20);

    // Requester 1 held: stalls at MAX_OUT, then one grant after each done
    do_reset();
    @(negedge clk);
    b = cyc;
    req = 4'b0010;
    push_g(1, b + 1);
    push_g(1, b + 2);
    push_g(1, b + 3);
    push_g(1, b + 11);
    push_g(1, b + 12);
    push_d(1, b + 10);
    push_d(1, b + 11);
    push_d(1, b + 12);
    push_d(1, b + 20);
    push_d(1, b + 21);
    repeat (12) @(negedge clk);
    req = '0;
    wait_to(b + 24);
    check("t3_busy_end", int'(busy), 0);

    // en dropped after two grants
    do_reset();
    @(negedge clk);
    b = cyc;
    req = 4'b1111;
    push_g(0, b + 1);
    push_g(1, b + 2);
    push_d(0, b + 10);
    push_d(1, b + 11);
    repeat (2) @(negedge clk);
    en = 1'b0;
    wait_to(b + 11);
    check("t4_busy_last", int'(busy), 1);
    wait_to(b + 13);
    check("t4_busy_fall", int'(busy), 0);
    req = '0;
    en  = 1'b1;
    wait_to(b + 20);
    check("t4_err_clean", int'(err), 0);

    // Spurious pipe_dout with nothing in flight
    b = cyc;
    force_dout = 1'b1;
    @(negedge clk);
    force_dout = 1'b0;
    check("t5_err_rise", int'(err), CHK);
    wait_to(b + 5);
    check("t5_err_sticky", int'(err), CHK);
    do_reset();
    @(negedge clk);
    check("t5_err_cleared", int'(err), 0);

    // Reset with three tokens in flight: no done, stale dout masked
    b = cyc;
    req = 4'b1111;
    push_g(0, b + 1);
    push_g(1, b + 2);
    push_g(2, b + 3);
    repeat (3) @(negedge clk);
    req = '0;
    wait_to(b + 5);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_to(b + 22);
    check("t6_err", int'(err), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);

    check("gnt_queue_drained", gq.size(), 0);
    check("done_queue_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
